// File: rtl/sumador_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: state encoding and default width.
package sumador_pkg;

   localparam int N_DEF = 4;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      SUMA = 2'b01,
      FIN  = 2'b10
   } estado_t;

endpackage

// File: rtl/sumador_restador_serie_if.sv
// Operand/result bundle of the serial adder/subtractor; master drives operands, slave returns results.
interface sumador_restador_serie_if #(
   parameter int N = sumador_pkg::N_DEF
);
   logic         inicio;
   logic         resta;
   logic [N-1:0] A;
   logic [N-1:0] B;
   logic         C0;
   logic [N-1:0] Sum;
   logic         C_out;
   logic         V;
   logic         ocupado;
   logic         listo;

   modport master (
      output inicio, resta, A, B, C0,
      input  Sum, C_out, V, ocupado, listo
   );

   modport slave (
      input  inicio, resta, A, B, C0,
      output Sum, C_out, V, ocupado, listo
   );
endinterface

// File: rtl/sumador_completo.sv
// One-bit full adder cell shared by every bit position of the serial datapath.
module sumador_completo (
   input  logic a_i,
   input  logic b_i,
   input  logic ci_i,
   output logic s_o,
   output logic co_o
);
   assign s_o  = a_i ^ b_i ^ ci_i;
   assign co_o = (a_i & b_i) | (a_i & ci_i) | (b_i & ci_i);
endmodule

// File: rtl/sumador_restador_serie.sv
// Bit-serial adder/subtractor: LSB-first through one full-adder cell, N cycles per operation.
module sumador_restador_serie
   import sumador_pkg::*;
#(
   parameter int N  = N_DEF,
   parameter int CW = 3
) (
   input logic                    clk,
   input logic                    reset,
   sumador_restador_serie_if.slave bus
);

   estado_t       estado_q;
   logic [N-1:0]  ra_q, rb_q, sum_q;
   logic          carry_q;
   logic [CW-1:0] cnt_q;
   logic          cout_q, v_q, ocupado_q, listo_q;
   logic          s_d, co_d;

   sumador_completo u_fa (
      .a_i  (ra_q[0]),
      .b_i  (rb_q[0]),
      .ci_i (carry_q),
      .s_o  (s_d),
      .co_o (co_d)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         estado_q  <= IDLE;
         ra_q      <= '0;
         rb_q      <= '0;
         sum_q     <= '0;
         carry_q   <= 1'b0;
         cnt_q     <= '0;
         cout_q    <= 1'b0;
         v_q       <= 1'b0;
         ocupado_q <= 1'b0;
         listo_q   <= 1'b0;
      end else begin
         case (estado_q)
            IDLE, FIN: begin
               listo_q <= 1'b0;
               if (bus.inicio) begin
                  // Subtraction as A + ~B + 1: invert B and force the initial carry.
                  ra_q      <= bus.A;
                  rb_q      <= bus.B ^ {N{bus.resta}};
                  carry_q   <= bus.resta ? 1'b1 : bus.C0;
                  cnt_q     <= '0;
                  sum_q     <= '0;
                  cout_q    <= 1'b0;
                  v_q       <= 1'b0;
                  ocupado_q <= 1'b1;
                  estado_q  <= SUMA;
               end else begin
                  ocupado_q <= 1'b0;
                  estado_q  <= IDLE;
               end
            end
            SUMA: begin
               ra_q    <= ra_q >> 1;
               rb_q    <= rb_q >> 1;
               sum_q   <= {s_d, sum_q[N-1:1]};
               carry_q <= co_d;
               cnt_q   <= cnt_q + CW'(1);
               if (cnt_q == CW'(N - 1)) begin
                  // carry_q is the carry into the MSB at this point
                  cout_q    <= co_d;
                  v_q       <= carry_q ^ co_d;
                  ocupado_q <= 1'b0;
                  listo_q   <= 1'b1;
                  estado_q  <= FIN;
               end
            end
            default: begin
               ocupado_q <= 1'b0;
               listo_q   <= 1'b0;
               estado_q  <= IDLE;
            end
         endcase
      end
   end

   assign bus.Sum     = sum_q;
   assign bus.C_out   = cout_q;
   assign bus.V       = v_q;
   assign bus.ocupado = ocupado_q;
   assign bus.listo   = listo_q;

endmodule

// File: tb/tb_sumador_restador_serie.sv
// Directed table plus multi-cycle corner sequences and an exhaustive N=4 sweep against a signed model.
module tb_sumador_restador_serie;

   localparam int N = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   sumador_restador_serie_if #(.N(N)) bus ();

   sumador_restador_serie #(.N(N), .CW(3)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   typedef struct {
      string    nm;
      bit       rs;
      bit [3:0] a;
      bit [3:0] b;
      bit       c0;
      bit [3:0] sum;
      bit       co;
      bit       v;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Caller is at a negedge; returns at the negedge sample where listo is seen (FIN cycle).
   task automatic run_op(input bit rs, input bit [3:0] a, input bit [3:0] b, input bit c0,
                         input bit poke, output int lat, output int busy);
      bus.resta  = rs;
      bus.A      = a;
      bus.B      = b;
      bus.C0     = c0;
      bus.inicio = 1'b1;
      @(posedge clk);
      lat  = 0;
      busy = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         lat++;
         if (bus.ocupado) busy++;
         if (lat == 1) bus.inicio = 1'b0;
         if (poke && lat == 2) begin
            bus.inicio = 1'b1;
            bus.A      = 4'd1;
            bus.B      = 4'd1;
            bus.resta  = 1'b0;
            bus.C0     = 1'b1;
         end
         if (poke && lat == 3) bus.inicio = 1'b0;
         if (bus.listo) break;
      end
      bus.inicio = 1'b0;
   endtask

   task automatic model(input bit rs, input bit [3:0] a, input bit [3:0] b, input bit c0,
                        output bit [3:0] s, output bit co, output bit v);
      int u, sa, sb, sr;
      sa = (a >= 8) ? int'(a) - 16 : int'(a);
      sb = (b >= 8) ? int'(b) - 16 : int'(b);
      if (rs) begin
         u  = int'(a) + (15 - int'(b)) + 1;
         sr = sa - sb;
      end else begin
         u  = int'(a) + int'(b) + int'(c0);
         sr = sa + sb + int'(c0);
      end
      s  = u[3:0];
      co = u[4];
      v  = (sr > 7) || (sr < -8);
   endtask

   vec_t tbl[4];
   int   lat, busy, lcnt;
   bit [3:0] es;
   bit       eco, ev;

   initial begin
      tbl[0] = '{"add77",    1'b0, 4'd7,  4'd7,  1'b0, 4'hE, 1'b0, 1'b1};
      tbl[1] = '{"addcarry", 1'b0, 4'd15, 4'd15, 1'b1, 4'hF, 1'b1, 1'b0};
      tbl[2] = '{"sub53",    1'b1, 4'd5,  4'd3,  1'b1, 4'h2, 1'b1, 1'b0};
      tbl[3] = '{"sub35",    1'b1, 4'd3,  4'd5,  1'b0, 4'hE, 1'b0, 1'b0};

      reset = 1'b1;
      bus.inicio = 1'b0; bus.resta = 1'b0; bus.A = '0; bus.B = '0; bus.C0 = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_sum", bus.Sum, 0);
      chk("rst_cout", bus.C_out, 0);
      chk("rst_v", bus.V, 0);
      chk("rst_ocupado", bus.ocupado, 0);
      chk("rst_listo", bus.listo, 0);
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 4; i++) begin
         run_op(tbl[i].rs, tbl[i].a, tbl[i].b, tbl[i].c0, 1'b0, lat, busy);
         chk({tbl[i].nm, "_lat"}, lat, 5);
         chk({tbl[i].nm, "_busy"}, busy, 4);
         chk({tbl[i].nm, "_sum"}, bus.Sum, tbl[i].sum);
         chk({tbl[i].nm, "_cout"}, bus.C_out, tbl[i].co);
         chk({tbl[i].nm, "_v"}, bus.V, tbl[i].v);
         if (i < 3) begin
            @(negedge clk);
            chk({tbl[i].nm, "_hold_sum"}, bus.Sum, tbl[i].sum);
            chk({tbl[i].nm, "_idle_listo"}, bus.listo, 0);
         end
      end

      // Back-to-back: start accepted during the FIN cycle of 3-5
      chk("b2b_fin_listo", bus.listo, 1);
      run_op(1'b1, 4'd8, 4'd1, 1'b0, 1'b0, lat, busy);
      chk("b2b_lat", lat, 5);
      chk("b2b_sum", bus.Sum, 4'h7);
      chk("b2b_cout", bus.C_out, 1);
      chk("b2b_v", bus.V, 1);
      @(negedge clk);

      // inicio during SUMA must not disturb the running 7+7
      run_op(1'b0, 4'd7, 4'd7, 1'b0, 1'b1, lat, busy);
      chk("busy_lat", lat, 5);
      chk("busy_sum", bus.Sum, 4'hE);
      chk("busy_cout", bus.C_out, 0);
      chk("busy_v", bus.V, 1);
      @(negedge clk);
      chk("busy_after_ocupado", bus.ocupado, 0);

      // Reset two cycles into SUMA
      bus.resta = 1'b0; bus.A = 4'd15; bus.B = 4'd1; bus.C0 = 1'b1; bus.inicio = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.inicio = 1'b0;
      @(negedge clk);
      chk("mid_ocupado", bus.ocupado, 1);
      reset = 1'b1;
      @(negedge clk);
      chk("midrst_sum", bus.Sum, 0);
      chk("midrst_cout", bus.C_out, 0);
      chk("midrst_v", bus.V, 0);
      chk("midrst_ocupado", bus.ocupado, 0);
      chk("midrst_listo", bus.listo, 0);
      reset = 1'b0;
      lcnt = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (bus.listo || bus.ocupado) lcnt++;
      end
      chk("midrst_no_listo", lcnt, 0);

      // Exhaustive sweep, operations chained back-to-back
      for (int rs = 0; rs < 2; rs++)
         for (int c0 = 0; c0 < 2; c0++)
            for (int a = 0; a < 16; a++)
               for (int b = 0; b < 16; b++) begin
                  model(rs[0], a[3:0], b[3:0], c0[0], es, eco, ev);
                  run_op(rs[0], a[3:0], b[3:0], c0[0], 1'b0, lat, busy);
                  chk($sformatf("sw_lat r%0d c%0d a%0d b%0d", rs, c0, a, b), lat, 5);
                  chk($sformatf("sw_sum r%0d c%0d a%0d b%0d", rs, c0, a, b), bus.Sum, es);
                  chk($sformatf("sw_cout r%0d c%0d a%0d b%0d", rs, c0, a, b), bus.C_out, eco);
                  chk($sformatf("sw_v r%0d c%0d a%0d b%0d", rs, c0, a, b), bus.V, ev);
               end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
